// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA port.
// CPU has priority; DMA is forced in after MAX_WAIT consecutive denied cycles.
module dmem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic [7:0] dma_rdata,
  output logic       dma_rvalid,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [1:0] owner,
  output logic [7:0] stall_cnt
);

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'b00,
    OWN_CPU   = 2'b01,
    OWN_DMA   = 2'b10,
    OWN_FORCE = 2'b11
  } owner_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_CPU  = 2'b01,
    RD_DMA  = 2'b10
  } rd_e;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  owner_e     state, state_next;
  rd_e        rd_owner, rd_owner_next;
  logic [3:0] wait_cnt;
  logic [7:0] cpu_hold, dma_hold;
  logic       forced, cpu_grant, dma_grant;

  always_comb begin
    forced        = dma_req && (wait_cnt == WAIT_MAX);
    cpu_grant     = 1'b0;
    dma_grant     = 1'b0;
    state_next    = OWN_IDLE;
    rd_owner_next = RD_NONE;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (forced) begin
      dma_grant  = 1'b1;
      state_next = OWN_FORCE;
    end else if (cpu_req) begin
      cpu_grant  = 1'b1;
      state_next = OWN_CPU;
    end else if (dma_req) begin
      dma_grant  = 1'b1;
      state_next = OWN_DMA;
    end
    if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_we) rd_owner_next = RD_CPU;
    end else if (dma_grant) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      if (!dma_we) rd_owner_next = RD_DMA;
    end
  end

  assign cpu_stall  = cpu_req && !cpu_grant;
  assign dma_gnt    = dma_grant;
  assign owner      = state;
  assign dma_rvalid = (rd_owner == RD_DMA);

  // Returned read data goes only to the port that was granted the read;
  // otherwise each port keeps presenting its last returned value.
  assign cpu_rdata = (rd_owner == RD_CPU) ? mem_rdata : cpu_hold;
  assign dma_rdata = (rd_owner == RD_DMA) ? mem_rdata : dma_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OWN_IDLE;
      rd_owner  <= RD_NONE;
      wait_cnt  <= '0;
      cpu_hold  <= '0;
      dma_hold  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_next;
      rd_owner <= rd_owner_next;
      if (!dma_req || dma_grant) wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
      if (rd_owner == RD_CPU) cpu_hold <= mem_rdata;
      if (rd_owner == RD_DMA) dma_hold <= mem_rdata;
      if (cpu_stall && stall_cnt != 8'hff) stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a synchronous RAM model.
module tb_dmem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] dma_addr = '0, dma_wdata = '0;
  logic       dma_gnt;
  logic [7:0] dma_rdata;
  logic       dma_rvalid;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [1:0] owner;
  logic [7:0] stall_cnt;

  logic [7:0] mem [256];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  dmem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: read data 1 cycle after a read; garbage otherwise so stale data is visible.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 8'hee;
  end

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL reset_owner: got %b expected 00", owner); end
    n_cmp++; if (stall_cnt !== 8'h00) begin n_err++; $display("FAIL reset_stall_cnt: got %h expected 00", stall_cnt); end
    n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 18'h0) begin n_err++; $display("FAIL reset_mem: got en=%b we=%b a=%h d=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    n_cmp++; if ({dma_rvalid, dma_gnt, cpu_stall} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {dma_rvalid, dma_gnt, cpu_stall}); end
    n_cmp++; if ({cpu_rdata, dma_rdata} !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h/%h expected 00/00", cpu_rdata, dma_rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cpu_load();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    #1;
    n_cmp++; if ({mem_en, mem_we, cpu_stall} !== 3'b100) begin n_err++; $display("FAIL cpu_load_ctl: got en/we/stall=%b expected 100", {mem_en, mem_we, cpu_stall}); end
    n_cmp++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL cpu_load_addr: got %h expected 10", mem_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (cpu_rdata !== 8'h5a) begin n_err++; $display("FAIL cpu_load_data: got %h expected 5a", cpu_rdata); end
    n_cmp++; if (owner !== 2'b01) begin n_err++; $display("FAIL cpu_load_owner: got %b expected 01", owner); end
    @(negedge clk);
    #1;
    n_cmp++; if (cpu_rdata !== 8'h5a) begin n_err++; $display("FAIL cpu_load_hold: got %h expected 5a", cpu_rdata); end
    n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL cpu_load_idle: got %b expected 00", owner); end
  endtask

  task automatic test_contention();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h50; dma_wdata = 8'h77;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c < 5) begin
        n_cmp++; if ({dma_gnt, cpu_stall, mem_we} !== 3'b000 || mem_addr !== 8'h40) begin n_err++; $display("FAIL contend_cpu_c%0d: got gnt/stall/we=%b addr=%h expected 000 addr 40", c, {dma_gnt, cpu_stall, mem_we}, mem_addr); end
      end else begin
        n_cmp++; if ({dma_gnt, cpu_stall, mem_we} !== 3'b111 || mem_addr !== 8'h50 || mem_wdata !== 8'h77) begin n_err++; $display("FAIL contend_force: got gnt/stall/we=%b addr=%h wd=%h expected 111 addr 50 wd 77", {dma_gnt, cpu_stall, mem_we}, mem_addr, mem_wdata); end
      end
      @(negedge clk);
      n_cmp++; if (owner !== ((c < 5) ? 2'b01 : 2'b11)) begin n_err++; $display("FAIL contend_owner_c%0d: got %b expected %b", c, owner, (c < 5) ? 2'b01 : 2'b11); end
    end
    n_cmp++; if (stall_cnt !== 8'd1) begin n_err++; $display("FAIL contend_stall_cnt: got %0d expected 1", stall_cnt); end
    dma_req = 1'b0;
    #1;
    n_cmp++; if (cpu_stall !== 1'b0 || mem_addr !== 8'h40) begin n_err++; $display("FAIL contend_resume: got stall=%b addr=%h expected 0 addr 40", cpu_stall, mem_addr); end
    @(negedge clk);
    n_cmp++; if (owner !== 2'b01 || stall_cnt !== 8'd1) begin n_err++; $display("FAIL contend_after: got owner=%b cnt=%0d expected 01 cnt 1", owner, stall_cnt); end
    n_cmp++; if (mem[8'h50] !== 8'h77) begin n_err++; $display("FAIL contend_dma_write: got %h expected 77", mem[8'h50]); end
    idle_inputs();
  endtask

  task automatic test_dma_read();
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    #1;
    n_cmp++; if ({dma_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 8'h20) begin n_err++; $display("FAIL dma_read_grant: got gnt/en/we=%b addr=%h expected 110 addr 20", {dma_gnt, mem_en, mem_we}, mem_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hc3) begin n_err++; $display("FAIL dma_read_return: got v=%b d=%h expected 1 c3", dma_rvalid, dma_rdata); end
    n_cmp++; if (owner !== 2'b10) begin n_err++; $display("FAIL dma_read_owner: got %b expected 10", owner); end
    @(negedge clk);
    #1;
    n_cmp++; if (dma_rvalid !== 1'b0 || dma_rdata !== 8'hc3) begin n_err++; $display("FAIL dma_read_hold: got v=%b d=%h expected 0 c3", dma_rvalid, dma_rdata); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h21;
    @(negedge clk);
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h11;
    #1;
    n_cmp++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h3c) begin n_err++; $display("FAIL b2b_dma_return: got v=%b d=%h expected 1 3c", dma_rvalid, dma_rdata); end
    n_cmp++; if ({mem_en, mem_we, cpu_stall, dma_gnt} !== 4'b1100 || mem_addr !== 8'h30 || mem_wdata !== 8'h11) begin n_err++; $display("FAIL b2b_store: got en/we/stall/gnt=%b a=%h d=%h expected 1100 a 30 d 11", {mem_en, mem_we, cpu_stall, dma_gnt}, mem_addr, mem_wdata); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL b2b_cross_route: got cpu_rdata=%h expected 00", cpu_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (mem[8'h30] !== 8'h11 || dma_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_after: got mem30=%h v=%b expected 11 0", mem[8'h30], dma_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    int found;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 8'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    repeat (3) @(negedge clk);
    cpu_req = 1'b0;
    #1;
    n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL rmr_grant: got %b expected 1", dma_gnt); end
    @(negedge clk);
    dma_req = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if ({dma_rvalid, owner, stall_cnt, dma_rdata} !== 19'h0) begin n_err++; $display("FAIL rmr_in_reset: got v=%b owner=%b cnt=%h d=%h expected all 0", dma_rvalid, owner, stall_cnt, dma_rdata); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_release0: got %b expected 0", dma_rvalid); end
    @(negedge clk);
    n_cmp++; if (dma_rvalid !== 1'b0 || dma_rdata !== 8'h00) begin n_err++; $display("FAIL rmr_release1: got v=%b d=%h expected 0 00", dma_rvalid, dma_rdata); end
    cpu_req = 1'b1; dma_req = 1'b1;
    found = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (dma_gnt) begin found = c; break; end
      @(negedge clk);
    end
    n_cmp++; if (found != 5) begin n_err++; $display("FAIL rmr_wait_cleared: got forced in cycle %0d expected 5", found); end
    idle_inputs();
  endtask

  task automatic test_stall_saturate();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 8'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      if (i == 600) begin
        n_cmp++; if (stall_cnt !== 8'd120) begin n_err++; $display("FAIL stall_cnt_600: got %0d expected 120", stall_cnt); end
      end
    end
    n_cmp++; if (stall_cnt !== 8'hff) begin n_err++; $display("FAIL stall_cnt_sat: got %h expected ff", stall_cnt); end
    idle_inputs();
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h10] = 8'h5a;
    mem[8'h20] = 8'hc3;
    mem[8'h21] = 8'h3c;
    test_reset();
    test_cpu_load();
    test_contention();
    test_dma_read();
    test_back_to_back();
    test_reset_mid_read();
    test_stall_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
